bcd2bin: RTL



---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd2bin_if.sv | 18 +
 rtl/bcd_digit_adj.sv | 7 +
 rtl/bcd2bin.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: default sizes, FSM encoding, digit limit.
package bcd_pkg;

    localparam int unsigned DIGITS_DEF = 6;
    localparam int unsigned BIN_W_DEF  = 20;
    localparam int unsigned OUT_W_DEF  = 32;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/bcd2bin_if.sv
// rdy/en/done handshake and data bus between a decimal-entry source and the converter.
interface bcd2bin_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
);
    logic [4*DIGITS-1:0] din;
    logic                en;
    logic                rdy;
    logic                busy;
    logic                done;
    logic                err;
    logic [OUT_W-1:0]    dout;

    modport master (output din, en, input  rdy, busy, done, err, dout);
    modport slave  (input  din, en, output rdy, busy, done, err, dout);
endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a shifted digit of 8 or more gets 3 removed.
module bcd_digit_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_c_o
);
    assign dig_c_o = (dig_i >= 4'd8) ? (dig_i - 4'd3) : dig_i;
endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: validate digits, then one right shift plus
// per-digit correction per clock for BIN_W clocks.
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd2bin_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               rdy_q, rdy_d;

    logic [BCD_W-1:0]   bcd_shift_c;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [BIN_W-1:0]   bin_shift_c;
    logic               bad_digit_c;

    // The bcd LSB falls into the top of the binary accumulator on each shift.
    assign bcd_shift_c = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_shift_c = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i   (bcd_shift_c[4*g +: 4]),
            .dig_c_o (bcd_adj_c[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit_c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > BCD_MAX_DIGIT) bad_digit_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (bus.en) begin
                    bcd_d   = bus.din;
                    bin_d   = '0;
                    err_d   = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad_digit_c) begin
                    err_d   = 1'b1;
                    dout_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_adj_c;
                bin_d = bin_shift_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    dout_d  = OUT_W'(bin_shift_c);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdy  = rdy_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.dout = dout_q;
endmodule
